// File: rtl/shreg_seq_ctrl.sv
// Command sequencer for the mode-controlled shift register: optional load, N shifts, capture.
// Optional abort support is enabled with `define SHREG_SEQ_ABORT_EN.
module shreg_seq_ctrl #(
    parameter int CNT_W = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_count,
    output logic [1:0]       m,
    output logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
`ifdef SHREG_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_t;

    typedef struct packed {
        logic             dir;
        logic [CNT_W-1:0] count;
    } cmd_t;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SR   = 2'b01;
    localparam logic [1:0] M_SL   = 2'b10;
    localparam logic [1:0] M_LD   = 2'b11;

    state_t state;
    cmd_t   cmd;

    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? M_SL : M_SR;
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // cmd.count doubles as the remaining-shift counter while in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd     <= '0;
            m       <= M_HOLD;
            x       <= '0;
            result  <= '0;
            done    <= 1'b0;
`ifdef SHREG_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SHREG_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    m <= M_HOLD;
                    if (req_valid) begin
                        cmd.dir   <= req_dir;
                        cmd.count <= req_count;
                        if (req_load) begin
                            x     <= req_data;
                            m     <= M_LD;
                            state <= LOAD;
                        end else if (req_count != '0) begin
                            m     <= shift_mode(req_dir);
                            state <= SHIFT;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                LOAD: begin
                    if (cmd.count != '0) begin
                        m     <= shift_mode(cmd.dir);
                        state <= SHIFT;
                    end else begin
                        m     <= M_HOLD;
                        state <= CAPTURE;
                    end
                end
                SHIFT: begin
                    cmd.count <= cmd.count - 1'b1;
                    if (cmd.count == CNT_W'(1)) begin
                        m     <= M_HOLD;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    m      <= M_HOLD;
                    result <= s;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    m     <= M_HOLD;
                    state <= IDLE;
                end
            endcase
`ifdef SHREG_SEQ_ABORT_EN
            // Abort overrides the case above; register contents stay wherever they got to.
            if (abort && (state == LOAD || state == SHIFT)) begin
                state     <= IDLE;
                m         <= M_HOLD;
                cmd.count <= '0;
                aborted   <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Directed bench for shreg_seq_ctrl with a behavioural 8-bit shift register on m/x/s.
module tb_shreg_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_load = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_dir = 1'b0;
    logic [3:0] req_count = 4'd0;
    logic [1:0] m;
    logic [7:0] x;
    logic [7:0] s;
    logic [7:0] result;
    logic       done;
    logic       busy;
`ifdef SHREG_SEQ_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    int total = 0;
    int bad = 0;
    logic [1:0] mhist [0:31];
    int nm, lat, rdy_low;
    logic [7:0] sreg = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (m)
            2'b01: sreg <= {1'b0, sreg[7:1]};
            2'b10: sreg <= {sreg[6:0], 1'b0};
            2'b11: sreg <= x;
            default: sreg <= sreg;
        endcase
    end
    assign s = sreg;

    shreg_seq_ctrl #(.CNT_W(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_data(req_data), .req_dir(req_dir), .req_count(req_count),
        .m(m), .x(x), .s(s),
        .result(result), .done(done), .busy(busy)
`ifdef SHREG_SEQ_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    // Records m each cycle after the accept edge until done; lat counts edges including accept.
    task automatic wait_done();
        nm = 0; lat = 1; rdy_low = 0;
        while (!done && lat < 40) begin
            if (nm < 32) begin mhist[nm] = m; nm++; end
            if (!req_ready) rdy_low++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic send_cmd(input logic ld, input logic [7:0] d, input logic dr, input logic [3:0] c);
        @(negedge clk);
        req_load = ld; req_data = d; req_dir = dr; req_count = c; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = 8'hC3; req_dir = ~dr;
        wait_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (m !== 2'b00) begin bad++; $display("FAIL reset_m: got %b want 00", m); end
        total++; if (x !== 8'h00) begin bad++; $display("FAIL reset_x: got %h want 00", x); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", result); end
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_done_busy: got %b%b want 00", done, busy); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_load_left();
        send_cmd(1'b1, 8'h54, 1'b1, 4'd1);
        total++; if (nm !== 3 || mhist[0] !== 2'b11 || mhist[1] !== 2'b10 || mhist[2] !== 2'b00) begin
            bad++; $display("FAIL left_mseq: got n=%0d %b %b %b want n=3 11 10 00", nm, mhist[0], mhist[1], mhist[2]); end
        total++; if (lat !== 4) begin bad++; $display("FAIL left_latency: got %0d want 4", lat); end
        total++; if (result !== 8'hA8) begin bad++; $display("FAIL left_result: got %h want a8", result); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL left_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_load_right();
        send_cmd(1'b1, 8'hAB, 1'b0, 4'd2);
        total++; if (nm !== 4 || mhist[0] !== 2'b11 || mhist[1] !== 2'b01 || mhist[2] !== 2'b01 || mhist[3] !== 2'b00) begin
            bad++; $display("FAIL right_mseq: got n=%0d %b %b %b %b want n=4 11 01 01 00", nm, mhist[0], mhist[1], mhist[2], mhist[3]); end
        total++; if (result !== 8'h2A) begin bad++; $display("FAIL right_result: got %h want 2a", result); end
        total++; if (rdy_low !== 4) begin bad++; $display("FAIL right_ready_low: got %0d want 4", rdy_low); end
        total++; if (lat !== 5) begin bad++; $display("FAIL right_latency: got %0d want 5", lat); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_load = 1'b1; req_data = 8'h00; req_dir = 1'b0; req_count = 4'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_data = 8'h54;
        wait_done();
        total++; if (nm !== 2 || mhist[0] !== 2'b11 || mhist[1] !== 2'b00) begin
            bad++; $display("FAIL b2b_mseq: got n=%0d %b %b want n=2 11 00", nm, mhist[0], mhist[1]); end
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency1: got %0d want 3", lat); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL b2b_result1: got %h want 00", result); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_in_done: got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (m !== 2'b11 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: got m=%b busy=%b done=%b want 11 1 0", m, busy, done); end
        wait_done();
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency2: got %0d want 3", lat); end
        total++; if (result !== 8'h54) begin bad++; $display("FAIL b2b_result2: got %h want 54", result); end
    endtask

    task automatic test_pure_read();
        send_cmd(1'b0, 8'h12, 1'b1, 4'd0);
        total++; if (nm !== 1 || mhist[0] !== 2'b00) begin bad++; $display("FAIL read_mseq: got n=%0d %b want n=1 00", nm, mhist[0]); end
        total++; if (lat !== 2) begin bad++; $display("FAIL read_latency: got %0d want 2", lat); end
        total++; if (result !== 8'h54) begin bad++; $display("FAIL read_result: got %h want 54", result); end
        total++; if (x !== 8'h54) begin bad++; $display("FAIL read_x_hold: got %h want 54", x); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_load = 1'b1; req_data = 8'hFF; req_dir = 1'b1; req_count = 4'd15; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (m !== 2'b10 || busy !== 1'b1) begin bad++; $display("FAIL mid_shifting: got m=%b busy=%b want 10 1", m, busy); end
        rst_n = 1'b0;
        #1;
        total++; if (m !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ctrl: got m=%b busy=%b done=%b want 00 0 0", m, busy, done); end
        total++; if (result !== 8'h00 || x !== 8'h00) begin bad++; $display("FAIL mid_reset_data: got result=%h x=%h want 00 00", result, x); end
        #10;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_release: got ready=%b busy=%b want 1 0", req_ready, busy); end
    endtask

`ifdef SHREG_SEQ_ABORT_EN
    task automatic test_abort();
        @(negedge clk);
        req_load = 1'b1; req_data = 8'hAB; req_dir = 1'b0; req_count = 4'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (aborted !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL abort_pulse: got aborted=%b done=%b want 1 0", aborted, done); end
        total++; if (m !== 2'b00 || req_ready !== 1'b1) begin bad++; $display("FAIL abort_idle: got m=%b ready=%b want 00 1", m, req_ready); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL abort_result: got %h want 00", result); end
        @(posedge clk); #1;
        total++; if (aborted !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_after: got aborted=%b done=%b want 0 0", aborted, done); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_left();
        test_load_right();
        test_back_to_back();
        test_pure_read();
        test_reset_mid();
`ifdef SHREG_SEQ_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
